// File: rtl/mmio_slot_bridge.sv
// mmio_slot_bridge: FPro MMIO bus to N_SLOT I/O cores.
// The bus address is split into a slot index and a register address. The
// bridge then drives a one-hot slot select with broadcast rd/wr strobes. The
// strobes are held until the selected slot acks, so slots can add wait states.
// An access to a slot index at or above N_SLOT completes at once with
// bus_err, and a read of such a slot returns zero.
// Optional feature, enabled by defining MMIO_BRIDGE_TIMEOUT_EN: an access is
// aborted when the slot has not acked after TIMEOUT_CYC cycles. A read that is
// aborted this way returns ERR_DATA.
module mmio_slot_bridge #(
  parameter int N_SLOT      = 64,
  parameter int SLOT_W      = 6,
  parameter int REG_W       = 5,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [20:0]          mmio_addr,
  input  logic [DW-1:0]        mmio_wr_data,
  output logic [DW-1:0]        mmio_rd_data,
  output logic                 mmio_ready,
  output logic [N_SLOT-1:0]    slot_cs,
  output logic                 slot_rd,
  output logic                 slot_wr,
  output logic [REG_W-1:0]     slot_reg_addr,
  output logic [DW-1:0]        slot_wr_data,
  input  logic [N_SLOT*DW-1:0] slot_rd_data,
  input  logic [N_SLOT-1:0]    slot_ack,
  output logic                 bus_err,
  output logic [SLOT_W-1:0]    err_slot
);

  localparam int NS_MAX = 2 ** SLOT_W;

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;

  logic [SLOT_W-1:0] req_slot;
  logic [REG_W-1:0]  req_reg;
  logic              req_go;
  logic              req_in_range;
  logic [NS_MAX-1:0] slot_valid;
  logic [N_SLOT-1:0] req_onehot;
  logic [DW-1:0]     sel_rd_data;
  logic              sel_ack;
  logic              unused_bits;

  assign req_slot     = mmio_addr[REG_W+SLOT_W-1:REG_W];
  assign req_reg      = mmio_addr[REG_W-1:0];
  assign req_go       = mmio_cs & (mmio_rd | mmio_wr);
  assign req_in_range = slot_valid[req_slot];

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]  to_cnt;
  logic [SLOT_W-1:0] cur_slot;
  logic              expired;
  // The current cycle is the TIMEOUT_CYC-th ACCESS cycle without an ack.
  assign expired     = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign unused_bits = ^mmio_addr[20:REG_W+SLOT_W];
`else
  assign unused_bits = ^{mmio_addr[20:REG_W+SLOT_W], ERR_DATA, 32'(TIMEOUT_CYC)};
`endif

  // Build the implemented-slot mask and the one-hot decode of the requested slot.
  always_comb begin
    slot_valid = '0;
    req_onehot = '0;
    for (int i = 0; i < NS_MAX; i++) slot_valid[i] = (i < N_SLOT);
    for (int s = 0; s < N_SLOT; s++) req_onehot[s] = (req_slot == SLOT_W'(s));
  end

  // Select read data and ack from the active slot only. slot_cs is one-hot or zero.
  always_comb begin
    sel_rd_data = '0;
    for (int s = 0; s < N_SLOT; s++)
      if (slot_cs[s]) sel_rd_data = sel_rd_data | slot_rd_data[s*DW +: DW];
    sel_ack = |(slot_ack & slot_cs);
  end

  // Bridge FSM. Every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      mmio_ready    <= 1'b1;
      mmio_rd_data  <= '0;
      slot_cs       <= '0;
      slot_rd       <= 1'b0;
      slot_wr       <= 1'b0;
      slot_reg_addr <= '0;
      slot_wr_data  <= '0;
      bus_err       <= 1'b0;
      err_slot      <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      to_cnt        <= '0;
      cur_slot      <= '0;
`endif
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_go) begin
            slot_reg_addr <= req_reg;
            slot_wr_data  <= mmio_wr_data;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
            to_cnt        <= '0;
            cur_slot      <= req_slot;
`endif
            if (req_in_range) begin
              state      <= ACCESS;
              mmio_ready <= 1'b0;
              slot_cs    <= req_onehot;
              // When rd and wr are both set, the write takes priority.
              slot_wr    <= mmio_wr;
              slot_rd    <= ~mmio_wr;
            end else begin
              if (!mmio_wr) mmio_rd_data <= '0;
              bus_err  <= 1'b1;
              err_slot <= req_slot;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            state      <= IDLE;
            mmio_ready <= 1'b1;
            slot_cs    <= '0;
            slot_rd    <= 1'b0;
            slot_wr    <= 1'b0;
            if (slot_rd) mmio_rd_data <= sel_rd_data;
          end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
          else if (expired) begin
            state      <= IDLE;
            mmio_ready <= 1'b1;
            slot_cs    <= '0;
            slot_rd    <= 1'b0;
            slot_wr    <= 1'b0;
            if (slot_rd) mmio_rd_data <= ERR_DATA;
            bus_err    <= 1'b1;
            err_slot   <= cur_slot;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// Directed bench for mmio_slot_bridge, configured with 16 slots and TIMEOUT_CYC=8.
// Expected read data is queued when a request is issued. It is checked when
// the bridge signals completion.
module tb_mmio_slot_bridge;

  localparam int NS = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             mmio_cs, mmio_wr, mmio_rd;
  logic [20:0]      mmio_addr;
  logic [DW-1:0]    mmio_wr_data;
  logic [DW-1:0]    mmio_rd_data;
  logic             mmio_ready;
  logic [NS-1:0]    slot_cs;
  logic             slot_rd, slot_wr;
  logic [4:0]       slot_reg_addr;
  logic [DW-1:0]    slot_wr_data;
  logic [NS*DW-1:0] slot_rd_data;
  logic [NS-1:0]    slot_ack;
  logic             bus_err;
  logic [5:0]       err_slot;

  logic [DW-1:0] slot_mem [NS];
  logic [NS-1:0] ack_tie;

  int total = 0;
  int bad = 0;
  int strobe_cycles = 0;
  int err_pulses = 0;
  int wr_commits = 0;
  logic [DW-1:0] wr_seen = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;

  mmio_slot_bridge #(.N_SLOT(NS), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .mmio_ready(mmio_ready), .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data),
    .slot_ack(slot_ack), .bus_err(bus_err), .err_slot(err_slot)
  );

  always #5 clk = ~clk;

  assign slot_ack = ack_tie;

  always_comb begin
    slot_rd_data = '0;
    for (int s = 0; s < NS; s++) slot_rd_data[s*DW +: DW] = slot_mem[s];
  end

  // Bus monitors: strobe cycles, error pulses and committed writes.
  always @(posedge clk) begin
    if (slot_rd | slot_wr) strobe_cycles <= strobe_cycles + 1;
    if (bus_err) err_pulses <= err_pulses + 1;
    if (slot_wr && |(slot_cs & slot_ack)) begin
      wr_commits <= wr_commits + 1;
      wr_seen    <= slot_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [20:0] addr,
                       input logic [31:0] data);
    mmio_cs = 1'b1; mmio_rd = rd; mmio_wr = wr; mmio_addr = addr; mmio_wr_data = data;
    tick();
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget, output int waited);
    waited = 0;
    while (mmio_ready !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    chk({tag, "_ready"}, 32'(mmio_ready), 32'd1);
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rd_data"}, mmio_rd_data, e);
    end
  endtask

  task automatic push_rd(input int s);
    held = slot_mem[s];
    exp_q.push_back(held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s0, e0, c0;
    reset = 1'b0; mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0; held = '0;
    ack_tie = 16'hFFDB;
    for (int i = 0; i < NS; i++) slot_mem[i] = 32'h1000_0000 + i;
    slot_mem[3] = 32'h1234_5678;
    slot_mem[2] = 32'h2222_0002;
    tick(); tick();

    // Reset state
    chk("rst_cs", 32'(slot_cs), 32'h0);
    chk("rst_rd", 32'(slot_rd), 32'h0);
    chk("rst_wr", 32'(slot_wr), 32'h0);
    chk("rst_reg", 32'(slot_reg_addr), 32'h0);
    chk("rst_wdata", slot_wr_data, 32'h0);
    chk("rst_rdata", mmio_rd_data, 32'h0);
    chk("rst_ready", 32'(mmio_ready), 32'h1);
    chk("rst_err", 32'(bus_err), 32'h0);
    chk("rst_errslot", 32'(err_slot), 32'h0);
    reset = 1'b1;
    tick();

    // Zero-wait read: slot 3, reg 7
    issue(1'b1, 1'b0, 21'h00067, 32'h0);
    push_rd(3);
    chk("zw_cs", 32'(slot_cs), 32'h8);
    chk("zw_rd", 32'(slot_rd), 32'h1);
    chk("zw_wr", 32'(slot_wr), 32'h0);
    chk("zw_reg", 32'(slot_reg_addr), 32'h7);
    chk("zw_busy", 32'(mmio_ready), 32'h0);
    wait_ready("zw", 4, w);
    chk("zw_latency", 32'(w), 32'd1);
    sb_check("zw");

    // Back-to-back read of slot 4, reg 9
    issue(1'b1, 1'b0, 21'h00089, 32'h0);
    push_rd(4);
    chk("b2b_cs", 32'(slot_cs), 32'h10);
    chk("b2b_reg", 32'(slot_reg_addr), 32'h9);
    wait_ready("b2b", 4, w);
    chk("b2b_latency", 32'(w), 32'd1);
    sb_check("b2b");

    // Wait-state write: slot 5 acks 3 cycles after the strobe
    s0 = strobe_cycles; c0 = wr_commits;
    issue(1'b0, 1'b1, 21'h000A2, 32'hCAFE_0001);
    exp_q.push_back(held);
    for (int i = 0; i < 3; i++) begin
      chk("ws_busy", 32'(mmio_ready), 32'h0);
      chk("ws_wr", 32'(slot_wr), 32'h1);
      chk("ws_wdata", slot_wr_data, 32'hCAFE_0001);
      chk("ws_nocommit", 32'(wr_commits - c0), 32'd0);
      tick();
    end
    ack_tie[5] = 1'b1;
    chk("ws_wr_ackcyc", 32'(slot_wr), 32'h1);
    wait_ready("ws", 4, w);
    ack_tie[5] = 1'b0;
    chk("ws_latency", 32'(w), 32'd1);
    chk("ws_wr_drop", 32'(slot_wr), 32'h0);
    chk("ws_strobe_len", 32'(strobe_cycles - s0), 32'd4);
    chk("ws_commits", 32'(wr_commits - c0), 32'd1);
    chk("ws_seen", wr_seen, 32'hCAFE_0001);
    sb_check("ws");

    // Out-of-range read: slot 20
    e0 = err_pulses;
    issue(1'b1, 1'b0, 21'h00281, 32'h0);
    held = '0;
    exp_q.push_back(held);
    chk("oor_cs", 32'(slot_cs), 32'h0);
    chk("oor_rd", 32'(slot_rd), 32'h0);
    chk("oor_err", 32'(bus_err), 32'h1);
    chk("oor_errslot", 32'(err_slot), 32'd20);
    chk("oor_ready", 32'(mmio_ready), 32'h1);
    sb_check("oor");
    tick();
    chk("oor_err_drop", 32'(bus_err), 32'h0);
    chk("oor_errslot_hold", 32'(err_slot), 32'd20);
    chk("oor_pulses", 32'(err_pulses - e0), 32'd1);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    // Timeout read of slot 2 with no ack
    s0 = strobe_cycles;
    issue(1'b1, 1'b0, 21'h00040, 32'h0);
    held = 32'hDEAD_BEEF;
    exp_q.push_back(held);
    wait_ready("to", 20, w);
    chk("to_wait", 32'(w), 32'd8);
    chk("to_strobe_len", 32'(strobe_cycles - s0), 32'd8);
    chk("to_err", 32'(bus_err), 32'h1);
    chk("to_errslot", 32'(err_slot), 32'd2);
    chk("to_cs", 32'(slot_cs), 32'h0);
    sb_check("to");
    tick();
    chk("to_err_drop", 32'(bus_err), 32'h0);
    // Ack on the expiry cycle wins
    issue(1'b1, 1'b0, 21'h00040, 32'h0);
    push_rd(2);
    for (int i = 0; i < 7; i++) tick();
    chk("toa_busy", 32'(mmio_ready), 32'h0);
    ack_tie[2] = 1'b1;
    wait_ready("toa", 4, w);
    ack_tie[2] = 1'b0;
    chk("toa_latency", 32'(w), 32'd1);
    chk("toa_err", 32'(bus_err), 32'h0);
    sb_check("toa");
`else
    // No timeout: an unacked access waits indefinitely
    e0 = err_pulses;
    issue(1'b1, 1'b0, 21'h00040, 32'h0);
    push_rd(2);
    for (int i = 0; i < 12; i++) tick();
    chk("nto_busy", 32'(mmio_ready), 32'h0);
    chk("nto_rd", 32'(slot_rd), 32'h1);
    chk("nto_cs", 32'(slot_cs), 32'h4);
    ack_tie[2] = 1'b1;
    wait_ready("nto", 4, w);
    ack_tie[2] = 1'b0;
    chk("nto_latency", 32'(w), 32'd1);
    chk("nto_pulses", 32'(err_pulses - e0), 32'd0);
    sb_check("nto");
`endif

    // Reset mid-access, then a normal access with high address bits set
    issue(1'b1, 1'b0, 21'h000A3, 32'h0);
    chk("mr_cs_before", 32'(slot_cs), 32'h20);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_cs", 32'(slot_cs), 32'h0);
    chk("mr_ready", 32'(mmio_ready), 32'h1);
    chk("mr_rd", 32'(slot_rd), 32'h0);
    chk("mr_rdata", mmio_rd_data, 32'h0);
    exp_q.delete();
    held = '0;
    tick();
    reset = 1'b1;
    tick();
    issue(1'b1, 1'b0, 21'h100067, 32'h0);
    push_rd(3);
    chk("mr_next_cs", 32'(slot_cs), 32'h8);
    wait_ready("mr_next", 4, w);
    chk("mr_next_latency", 32'(w), 32'd1);
    sb_check("mr_next");

    // A request presented while busy is ignored
    issue(1'b0, 1'b1, 21'h000A0, 32'h0BAD_0BAD);
    exp_q.push_back(held);
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = 21'h00067;
    tick();
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    chk("busy_cs", 32'(slot_cs), 32'h20);
    chk("busy_rd", 32'(slot_rd), 32'h0);
    chk("busy_wr", 32'(slot_wr), 32'h1);
    ack_tie[5] = 1'b1;
    wait_ready("busy", 4, w);
    ack_tie[5] = 1'b0;
    sb_check("busy");
    chk("busy_seen", wr_seen, 32'h0BAD_0BAD);
    tick();
    chk("busy_no_second", 32'(slot_cs), 32'h0);

    // rd and wr both set: the request is treated as a write
    issue(1'b1, 1'b1, 21'h0006C, 32'hA5A5_A5A5);
    exp_q.push_back(held);
    chk("cf_cs", 32'(slot_cs), 32'h8);
    chk("cf_wr", 32'(slot_wr), 32'h1);
    chk("cf_rd", 32'(slot_rd), 32'h0);
    chk("cf_reg", 32'(slot_reg_addr), 32'hC);
    wait_ready("cf", 4, w);
    sb_check("cf");
    chk("cf_seen", wr_seen, 32'hA5A5_A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
